i2c_master_tx: RTL

//  Write-only I2C master. It sits directly downstream of the 8-bit byte FIFO and drains it onto the bus.
//  On start it transmits: START, 7-bit address + W, then FIFO bytes MSB-first, then STOP.
//  It checks the slave ACK after every byte and aborts with STOP on a NACK.
//  SCL and SDA are open-drain: an oe output of 1 pulls the line low; 0 releases it.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_tick_gen.sv | 47 ++++
 rtl/i2c_master_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the write-only I2C master.
//   state_t   - transfer FSM states
//   quarter_t - index of the SCL quarter-period within one bit
//   I2C_WR    - R/W bit value for a write transfer
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    FETCH,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: SCL quarter-period timebase.
// A down-counter reloads to CLK_DIV-1 and fires a one-cycle tick at terminal
// count; every tick advances the quarter index Q0->Q1->Q2->Q3->Q0.
// Ports:
//   clk, reset  system clock, async active-low reset
//   en          run enable; when low the counter and quarter are re-armed so
//               the next enabled period starts with a full-length Q0
//   hold        freezes counter and quarter (FSM fetch, clock stretching)
//   tick        end of the current quarter
//   quarter     current quarter index
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  input  logic     hold,
  output logic     tick,
  output quarter_t quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= Q0;
    end else if (!en) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= Q0;
    end else if (!hold) begin
      if (cnt == '0) begin
        cnt     <= CW'(CLK_DIV - 1);
        quarter <= quarter_t'(quarter + 2'd1);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master draining a byte FIFO onto the bus.
// Sends START, {addr,W}, FIFO bytes MSB-first, STOP; aborts with STOP on NACK.
// SCL/SDA are open-drain: *_oe = 1 pulls the line low.
// Build option: define I2C_CLK_STRETCH_EN to let a slave holding SCL low
// stretch the high phase (quarter counter holds in Q1/Q2 while scl_in = 0).
// Ports:
//   clk, reset          system clock, async active-low reset
//   start               one-cycle request, accepted only in IDLE
//   slave_addr          7-bit target address, latched on start
//   byte_cnt            bytes to send (0 = until FIFO empty), latched on start
//   fifo_empty          FIFO empty flag
//   fifo_dout           FIFO read data, valid the cycle after fifo_rd
//   fifo_rd             one-cycle pop request
//   scl_oe, sda_oe      open-drain pull-down enables
//   sda_in, scl_in      sampled bus lines
//   busy                transfer in progress
//   done                one-cycle pulse on return to IDLE
//   nack_err            sticky NACK flag, cleared on the next accepted start
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, waiting for start
// START    | Q1: SDA falls with SCL high; Q3: SCL pulled low
// ADDR     | shifting {slave_addr, W}, 8 bits
// ADDR_ACK | SDA released, slave ACK sampled at end of Q2
// FETCH    | timebase frozen; decide STOP or pop one byte from the FIFO
// DATA     | shifting one data byte
// DATA_ACK | SDA released, slave ACK sampled; count byte on ACK
// STOP     | SDA low, SCL released, then SDA released
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        slave_addr,
  input  logic [7:0]        byte_cnt,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_in,
  input  logic              scl_in,
  output logic              busy,
  output logic              done,
  output logic              nack_err
);

  localparam int BCW = $clog2(DATA_W);

  state_t            state, state_nxt;
  quarter_t          quarter;
  logic              tick, hold, stretch_hold;
  logic              q_end, q_sample, bit_scl_oe, limit_hit;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic [7:0]        byte_cnt_q, sent;
  logic              ack_nack, rd_pend;

  assign busy       = (state != IDLE);
  assign q_end      = tick && (quarter == Q3);
  assign q_sample   = tick && (quarter == Q2);
  assign bit_scl_oe = (quarter == Q0) || (quarter == Q3);
  assign limit_hit  = fifo_empty || ((byte_cnt_q != 8'd0) && (sent == byte_cnt_q));

`ifdef I2C_CLK_STRETCH_EN
  assign stretch_hold = ((quarter == Q1) || (quarter == Q2)) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretch_hold  = 1'b0;
`endif

  // The timebase is frozen in FETCH so the next data bit starts with a full Q0.
  assign hold = (state == FETCH) || stretch_hold;

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (busy),
    .hold    (hold),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    fifo_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = START;
      end
      START: begin
        scl_oe = (quarter == Q3);
        sda_oe = (quarter != Q0);
        if (q_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl_oe = bit_scl_oe;
        sda_oe = ~shreg[DATA_W-1];
        if (q_end && (bit_cnt == '0)) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_oe = bit_scl_oe;
        if (q_end) state_nxt = ack_nack ? STOP : FETCH;
      end
      FETCH: begin
        scl_oe = 1'b1;
        // Once a pop is in flight the limit is not re-evaluated: fifo_empty
        // may already reflect the byte being loaded.
        if (rd_pend)        state_nxt = DATA;
        else if (limit_hit) state_nxt = STOP;
        else                fifo_rd   = 1'b1;
      end
      DATA: begin
        scl_oe = bit_scl_oe;
        sda_oe = ~shreg[DATA_W-1];
        if (q_end && (bit_cnt == '0)) state_nxt = DATA_ACK;
      end
      DATA_ACK: begin
        scl_oe = bit_scl_oe;
        if (q_end) state_nxt = ack_nack ? STOP : FETCH;
      end
      STOP: begin
        scl_oe = (quarter == Q0);
        sda_oe = (quarter != Q3);
        if (q_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt_q <= '0;
      sent       <= '0;
      ack_nack   <= 1'b0;
      rd_pend    <= 1'b0;
      nack_err   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == STOP) && q_end;
      case (state)
        IDLE: begin
          if (start) begin
            nack_err                <= 1'b0;
            byte_cnt_q              <= byte_cnt;
            sent                    <= '0;
            rd_pend                 <= 1'b0;
            shreg                   <= '0;
            shreg[DATA_W-1 -: 8]    <= {slave_addr, I2C_WR};
            bit_cnt                 <= BCW'(7);
          end
        end
        ADDR, DATA: begin
          if (q_end && (bit_cnt != '0)) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BCW'(1);
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (q_sample) ack_nack <= sda_in;
          if (q_end) begin
            if (ack_nack)                              nack_err <= 1'b1;
            else if ((state == DATA_ACK) && (sent != 8'hFF)) sent <= sent + 8'd1;
          end
        end
        FETCH: begin
          if (rd_pend) begin
            shreg   <= fifo_dout;
            bit_cnt <= BCW'(DATA_W - 1);
            rd_pend <= 1'b0;
          end else if (!limit_hit) begin
            rd_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
